// File: rtl/msrv32_alu_decoder.sv
// msrv32_alu_decoder: registered RV32I decode stage producing ALU opcode and operands
module msrv32_alu_decoder (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] rs1_data_in,
  input  logic [31:0] rs2_data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [31:0] op_1_out,
  output logic [31:0] op_2_out,
  output logic [3:0]  opcode_out,
  output logic [4:0]  rd_addr_out,
  output logic        wr_en_out,
  output logic        illegal_out,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [7:0]  illegal_count_out
);
  logic [6:0]  major, funct7;
  logic [2:0]  funct3;
  logic        is_op, is_imm, is_lui, is_auipc, is_shift, legal, accept;
  logic [31:0] op_1, op_2, upper;
  logic [3:0]  opcode;
  assign major    = instr_in[6:0];
  assign funct3   = instr_in[14:12];
  assign funct7   = instr_in[31:25];
  assign is_op    = major == 7'b0110011;
  assign is_imm   = major == 7'b0010011;
  assign is_lui   = major == 7'b0110111;
  assign is_auipc = major == 7'b0010111;
  assign is_shift = funct3 == 3'b001 || funct3 == 3'b101;
  assign upper    = {instr_in[31:12], 12'b0};
  assign ready_out = !valid_out || ready_in;
  assign accept    = valid_in && ready_out;
  always_comb begin
    legal = (is_op && (funct7 == 7'b0000000 ||
                       (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))) ||
            (is_imm && (funct3 == 3'b001 ? funct7 == 7'b0000000 :
                        funct3 == 3'b101 ? (funct7 == 7'b0000000 || funct7 == 7'b0100000) : 1'b1)) ||
            is_lui || is_auipc;
    opcode = is_op  ? {instr_in[30], funct3} :
             is_imm ? (funct3 == 3'b101 ? {instr_in[30], 3'b101} : {1'b0, funct3}) : 4'b0000;
    op_1 = is_auipc ? pc_in : (is_op || is_imm) ? rs1_data_in : 32'b0;
    // Shift amounts are masked to 5 bits because the ALU shifts by the full operand
    op_2 = is_op  ? (is_shift ? {27'b0, rs2_data_in[4:0]} : rs2_data_in) :
           is_imm ? (is_shift ? {27'b0, instr_in[24:20]} : {{20{instr_in[31]}}, instr_in[31:20]}) :
           upper;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      valid_out         <= 1'b0;
      illegal_out       <= 1'b0;
      wr_en_out         <= 1'b0;
      op_1_out          <= '0;
      op_2_out          <= '0;
      opcode_out        <= '0;
      rd_addr_out       <= '0;
      illegal_count_out <= '0;
    end else if (accept) begin
      valid_out   <= 1'b1;
      illegal_out <= !legal;
      wr_en_out   <= legal && instr_in[11:7] != 5'd0;
      op_1_out    <= legal ? op_1 : 32'b0;
      op_2_out    <= legal ? op_2 : 32'b0;
      opcode_out  <= legal ? opcode : 4'b0;
      rd_addr_out <= instr_in[11:7];
      if (!legal && illegal_count_out != 8'hFF) illegal_count_out <= illegal_count_out + 8'd1;
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_msrv32_alu_decoder.sv
// tb_msrv32_alu_decoder: table vectors, corner sequences and random stimulus against a decode model
module tb_msrv32_alu_decoder;
  logic        clk = 0, rst_n = 0, valid_in = 0, ready_in = 0;
  logic [31:0] instr = 0, pc = 0, rs1 = 0, rs2 = 0;
  logic        ready_out, wr_en_out, illegal_out, valid_out;
  logic [31:0] op_1_out, op_2_out;
  logic [3:0]  opcode_out;
  logic [4:0]  rd_addr_out;
  logic [7:0]  illegal_count_out;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  msrv32_alu_decoder dut (
    .clk_in(clk), .rst_n_in(rst_n), .instr_in(instr), .pc_in(pc),
    .rs1_data_in(rs1), .rs2_data_in(rs2), .valid_in(valid_in), .ready_out(ready_out),
    .op_1_out(op_1_out), .op_2_out(op_2_out), .opcode_out(opcode_out),
    .rd_addr_out(rd_addr_out), .wr_en_out(wr_en_out), .illegal_out(illegal_out),
    .valid_out(valid_out), .ready_in(ready_in), .illegal_count_out(illegal_count_out)
  );

  typedef struct packed {
    logic [31:0] op1, op2;
    logic [3:0]  opc;
    logic [4:0]  rd;
    logic        wr, ill;
  } dec_t;

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    dec_t        exp;
  } vec_t;

  dec_t m;
  logic m_valid = 0;
  int   m_count = 0;

  // Reference: decode by instruction class and the legality rules of RV32I
  function automatic dec_t ref_dec(input logic [31:0] i, input logic [31:0] p, a, b);
    dec_t d;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok;
    f3 = i[14:12];
    f7 = i[31:25];
    d = '0;
    d.rd = i[11:7];
    ok = 0;
    case (i[6:0])
      7'h33: begin
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        d.op1 = a;
        d.op2 = (f3 == 1 || f3 == 5) ? b % 32 : b;
        d.opc = {f7 == 7'h20, f3};
      end
      7'h13: begin
        ok = (f3 == 1) ? f7 == 0 : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1;
        d.op1 = a;
        d.op2 = (f3 == 1 || f3 == 5) ? 32'(i[24:20]) : $unsigned($signed(i) >>> 20);
        d.opc = (f3 == 5) ? {f7 == 7'h20, 3'b101} : {1'b0, f3};
      end
      7'h37: begin ok = 1; d.op2 = i & 32'hFFFFF000; end
      7'h17: begin ok = 1; d.op1 = p; d.op2 = i & 32'hFFFFF000; end
      default: ok = 0;
    endcase
    if (!ok) begin d.op1 = 0; d.op2 = 0; d.opc = 0; end
    d.ill = !ok;
    d.wr = ok && d.rd != 0;
    return d;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
    chk({tag, ".op1"}, op_1_out, m.op1);
    chk({tag, ".op2"}, op_2_out, m.op2);
    chk({tag, ".opcode"}, 32'(opcode_out), 32'(m.opc));
    chk({tag, ".rd"}, 32'(rd_addr_out), 32'(m.rd));
    chk({tag, ".wr_en"}, 32'(wr_en_out), 32'(m.wr));
    chk({tag, ".illegal"}, 32'(illegal_out), 32'(m.ill));
    chk({tag, ".count"}, 32'(illegal_count_out), 32'(m_count));
  endtask

  // One clock: drive inputs, check ready, advance the model, compare after the edge
  task automatic cycle(input string tag, input logic [31:0] i, p, a, b, input logic v, r);
    dec_t d;
    bit exp_ready, acc;
    instr = i; pc = p; rs1 = a; rs2 = b; valid_in = v; ready_in = r;
    #1;
    exp_ready = !m_valid || r;
    chk({tag, ".ready"}, 32'(ready_out), 32'(exp_ready));
    acc = v && exp_ready;
    d = ref_dec(i, p, a, b);
    @(posedge clk);
    #1;
    if (acc) begin
      m = d;
      m_valid = 1;
      if (d.ill && m_count < 255) m_count++;
    end else if (r) m_valid = 0;
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 0; valid_in = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    m = '0; m_valid = 0; m_count = 0;
    compare_all(tag);
    chk({tag, ".ready"}, 32'(ready_out), 32'd1);
  endtask

  localparam logic [31:0] JAL = 32'h0000006F;

  initial begin
    vec_t vecs[12];
    logic [31:0] h1, h2, r, ri;
    logic [3:0] hop;
    vecs[0]  = '{32'h002081B3, 0, 5, 32'hFFFFFFFF, '{32'd5, 32'hFFFFFFFF, 4'b0000, 5'd3, 1'b1, 1'b0}};
    vecs[1]  = '{32'h4030D213, 0, 32'h80, 0, '{32'h80, 32'd3, 4'b1101, 5'd4, 1'b1, 1'b0}};
    vecs[2]  = '{32'h40008213, 0, 7, 0, '{32'd7, 32'h400, 4'b0000, 5'd4, 1'b1, 1'b0}};
    vecs[3]  = '{32'h002092B3, 0, 9, 32'h121, '{32'd9, 32'd1, 4'b0001, 5'd5, 1'b1, 1'b0}};
    vecs[4]  = '{32'h12345297, 32'h100, 1, 2, '{32'h100, 32'h12345000, 4'b0000, 5'd5, 1'b1, 1'b0}};
    vecs[5]  = '{32'hABCDE037, 32'h40, 1, 2, '{32'd0, 32'hABCDE000, 4'b0000, 5'd0, 1'b0, 1'b0}};
    vecs[6]  = '{JAL, 32'h40, 3, 4, '{32'd0, 32'd0, 4'b0000, 5'd0, 1'b0, 1'b1}};
    vecs[7]  = '{32'h40208333, 0, 10, 3, '{32'd10, 32'd3, 4'b1000, 5'd6, 1'b1, 1'b0}};
    vecs[8]  = '{32'h4020F3B3, 0, 10, 3, '{32'd0, 32'd0, 4'b0000, 5'd7, 1'b0, 1'b1}};
    vecs[9]  = '{32'h40109213, 0, 10, 3, '{32'd0, 32'd0, 4'b0000, 5'd4, 1'b0, 1'b1}};
    vecs[10] = '{32'h0050D213, 0, 32'hF0, 0, '{32'hF0, 32'd5, 4'b0101, 5'd4, 1'b1, 1'b0}};
    vecs[11] = '{32'hFFF0B213, 0, 1, 0, '{32'd1, 32'hFFFFFFFF, 4'b0011, 5'd4, 1'b1, 1'b0}};

    m = '0;
    @(posedge clk);
    do_reset("reset");

    foreach (vecs[k]) begin
      cycle($sformatf("vec%0d", k), vecs[k].instr, vecs[k].pc, vecs[k].rs1, vecs[k].rs2, 1, 1);
      chk($sformatf("vec%0d.tbl_op1", k), op_1_out, vecs[k].exp.op1);
      chk($sformatf("vec%0d.tbl_op2", k), op_2_out, vecs[k].exp.op2);
      chk($sformatf("vec%0d.tbl_opc", k), 32'(opcode_out), 32'(vecs[k].exp.opc));
      chk($sformatf("vec%0d.tbl_wr", k), 32'(wr_en_out), 32'(vecs[k].exp.wr));
      chk($sformatf("vec%0d.tbl_ill", k), 32'(illegal_out), 32'(vecs[k].exp.ill));
    end
    chk("tbl_count", 32'(illegal_count_out), 32'd3);

    // Backpressure: a held entry must stay bit-stable while valid_in keeps pushing
    cycle("bp_load", 32'h002081B3, 0, 32'h11, 32'h22, 1, 1);
    h1 = op_1_out; h2 = op_2_out; hop = opcode_out;
    for (int k = 0; k < 4; k++) begin
      cycle("bp_hold", 32'h40208333, 0, 32'h33, 32'h44, 1, 0);
      chk("bp_ready_low", 32'(ready_out), 32'd0);
      chk("bp_op1_stable", op_1_out, h1);
      chk("bp_op2_stable", op_2_out, h2);
      chk("bp_opc_stable", 32'(opcode_out), 32'(hop));
    end
    cycle("bb0", 32'h40208333, 0, 32'h33, 32'h44, 1, 1);
    cycle("bb1", 32'h002081B3, 0, 32'h55, 32'h66, 1, 1);
    cycle("bb2", 32'h12345297, 32'h200, 0, 0, 1, 1);
    cycle("drain", 0, 0, 0, 0, 0, 1);

    // Saturation of the illegal counter
    for (int k = 0; k < 300; k++) cycle("sat", JAL, 0, 0, 0, 1, 1);
    chk("sat_count", 32'(illegal_count_out), 32'd255);

    // Reset while holding an instruction with count 7
    do_reset("reset2");
    for (int k = 0; k < 7; k++) cycle("pre_rst", JAL, 0, 0, 0, 1, 1);
    cycle("pre_rst_load", 32'h002081B3, 0, 5, 6, 1, 0);
    chk("pre_rst_count", 32'(illegal_count_out), 32'd7);
    chk("pre_rst_valid", 32'(valid_out), 32'd1);
    do_reset("mid_reset");

    // Random traffic with random handshakes
    for (int k = 0; k < 2000; k++) begin
      r = $urandom();
      ri = $urandom();
      case (r % 6)
        0, 1: ri[6:0] = 7'h33;
        2, 3: ri[6:0] = 7'h13;
        4:    ri[6:0] = (r[8]) ? 7'h37 : 7'h17;
        default: ;
      endcase
      case ((r >> 4) % 4)
        0, 1: ri[31:25] = 7'h00;
        2:    ri[31:25] = 7'h20;
        default: ;
      endcase
      cycle("rand", ri, $urandom(), $urandom(), $urandom(), r[12] | r[13], r[14] | r[15]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
